// File: rtl/font_rom_arbiter.sv
// Font ROM port arbiter: the video path owns the ROM during active display.
// Background requesters share the ROM in round-robin order during blanking.
module font_rom_arbiter #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned AW   = 11,
   parameter int unsigned DW   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               video_on,
   input  logic [AW-1:0]      vid_addr,
   output logic [DW-1:0]      vid_data,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      rom_addr,
   input  logic [DW-1:0]      rom_data,
   output logic               busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] ST_VIDEO = 1'b0;
   localparam logic [0:0] ST_ARB   = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0] rvalid_q;

   logic            lo_found, hi_found, grant_v;
   logic [PW-1:0]   lo_idx, hi_idx, winner;
   logic [AW-1:0]   win_addr;

   // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
   always_comb begin
      lo_found = 1'b0;
      hi_found = 1'b0;
      lo_idx   = '0;
      hi_idx   = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_found = 1'b1;
            lo_idx   = PW'(i);
            if (i >= int'(rr_ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = PW'(i);
            end
         end
      end
      winner  = hi_found ? hi_idx : lo_idx;
      grant_v = ~video_on & lo_found;
   end

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (int'(winner) == i) begin
            win_addr = req_addr[i*AW +: AW];
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (grant_v) begin
         gnt = NREQ'(1) << winner;
      end
   end

   assign rom_addr = grant_v ? win_addr : vid_addr;
   assign busy     = ~video_on & (|(req & ~gnt));
   assign vid_data = rom_data;
   assign rvalid   = rvalid_q;
   assign rdata    = (|rvalid_q) ? rom_data : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_v) begin
         rr_ptr_d = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   // The state register only tracks ownership; video_on priority itself is combinational.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_VIDEO: if (!video_on) state_d = ST_ARB;
         ST_ARB:   if (video_on)  state_d = ST_VIDEO;
         default:  state_d = ST_VIDEO;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_VIDEO;
         rr_ptr_q <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         rvalid_q <= gnt;
      end
   end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter with a registered font ROM model.
// ROM content: data = addr[7:0] ^ 8'h5A ^ {5'b0, addr[10:8]}.
module tb_font_rom_arbiter;

   logic        clk;
   logic        reset;
   logic        video_on;
   logic [10:0] vid_addr;
   logic [7:0]  vid_data;
   logic [2:0]  req;
   logic [32:0] req_addr;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [7:0]  rdata;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;
   logic        busy;

   int total = 0;
   int bad   = 0;

   font_rom_arbiter #(.NREQ(3), .AW(11), .DW(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .video_on (video_on),
      .vid_addr (vid_addr),
      .vid_data (vid_data),
      .req      (req),
      .req_addr (req_addr),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'h5A ^ {5'd0, rom_addr[10:8]};

   task automatic test_reset();
      reset = 1'b0; video_on = 1'b0; vid_addr = '0; req = '0;
      req_addr = {11'h322, 11'h211, 11'h100};
      repeat (2) @(negedge clk);
      #1;
      total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
   endtask

   task automatic test_video();
      @(negedge clk); reset = 1'b1; video_on = 1'b1; vid_addr = 11'h414; #1;
      total++; if (rom_addr !== 11'h414) begin bad++; $display("FAIL vid_rom_addr got=%h exp=414", rom_addr); end
      total++; if (gnt !== 3'b000) begin bad++; $display("FAIL vid_gnt got=%b exp=000", gnt); end
      @(negedge clk); #1;
      total++; if (vid_data !== 8'h4A) begin bad++; $display("FAIL vid_data got=%h exp=4a", vid_data); end
   endtask

   task automatic test_round_robin();
      @(negedge clk); video_on = 1'b0; req = 3'b111; #1;
      total++; if (gnt !== 3'b001) begin bad++; $display("FAIL rr_gnt0 got=%b exp=001", gnt); end
      total++; if (rom_addr !== 11'h100) begin bad++; $display("FAIL rr_addr0 got=%h exp=100", rom_addr); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy got=%b exp=1", busy); end
      @(negedge clk); #1;
      total++; if (gnt !== 3'b010) begin bad++; $display("FAIL rr_gnt1 got=%b exp=010", gnt); end
      total++; if (rvalid !== 3'b001) begin bad++; $display("FAIL rr_rvalid0 got=%b exp=001", rvalid); end
      total++; if (rdata !== 8'h5B) begin bad++; $display("FAIL rr_rdata0 got=%h exp=5b", rdata); end
      total++; if (rom_addr !== 11'h211) begin bad++; $display("FAIL rr_addr1 got=%h exp=211", rom_addr); end
      @(negedge clk); #1;
      total++; if (gnt !== 3'b100) begin bad++; $display("FAIL rr_gnt2 got=%b exp=100", gnt); end
      total++; if (rvalid !== 3'b010) begin bad++; $display("FAIL rr_rvalid1 got=%b exp=010", rvalid); end
      total++; if (rdata !== 8'h49) begin bad++; $display("FAIL rr_rdata1 got=%h exp=49", rdata); end
      @(negedge clk); req = 3'b000; #1;
      total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rr_gnt_idle got=%b exp=000", gnt); end
      total++; if (rvalid !== 3'b100) begin bad++; $display("FAIL rr_rvalid2 got=%b exp=100", rvalid); end
      total++; if (rdata !== 8'h7B) begin bad++; $display("FAIL rr_rdata2 got=%h exp=7b", rdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy_idle got=%b exp=0", busy); end
   endtask

   task automatic test_wrap();
      @(negedge clk); req = 3'b001; #1;
      total++; if (gnt !== 3'b001) begin bad++; $display("FAIL wrap_setup got=%b exp=001", gnt); end
      @(negedge clk); req = 3'b101; #1;
      total++; if (gnt !== 3'b100) begin bad++; $display("FAIL wrap_gnt2 got=%b exp=100", gnt); end
      @(negedge clk); req = 3'b001; #1;
      total++; if (gnt !== 3'b001) begin bad++; $display("FAIL wrap_gnt0 got=%b exp=001", gnt); end
      total++; if (rvalid !== 3'b100) begin bad++; $display("FAIL wrap_rvalid got=%b exp=100", rvalid); end
      // Pointer should now be 1, so requester 1 wins a full request set.
      @(negedge clk); req = 3'b111; #1;
      total++; if (gnt !== 3'b010) begin bad++; $display("FAIL wrap_ptr1 got=%b exp=010", gnt); end
      @(negedge clk); req = 3'b000;
   endtask

   task automatic test_last_blank();
      @(negedge clk); video_on = 1'b0; req = 3'b010; #1;
      total++; if (gnt !== 3'b010) begin bad++; $display("FAIL last_gnt got=%b exp=010", gnt); end
      @(negedge clk); req = 3'b000; video_on = 1'b1; vid_addr = 11'h0A5; #1;
      total++; if (rvalid !== 3'b010) begin bad++; $display("FAIL last_rvalid got=%b exp=010", rvalid); end
      total++; if (rdata !== 8'h49) begin bad++; $display("FAIL last_rdata got=%h exp=49", rdata); end
      total++; if (rom_addr !== 11'h0A5) begin bad++; $display("FAIL last_rom_addr got=%h exp=0a5", rom_addr); end
      total++; if (gnt !== 3'b000) begin bad++; $display("FAIL last_gnt_vid got=%b exp=000", gnt); end
   endtask

   task automatic test_video_priority();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); req = 3'b010; #1;
         total++; if (gnt !== 3'b000) begin bad++; $display("FAIL prio_gnt%0d got=%b exp=000", i, gnt); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_busy%0d got=%b exp=0", i, busy); end
      end
      @(negedge clk); video_on = 1'b0; #1;
      total++; if (gnt !== 3'b010) begin bad++; $display("FAIL prio_blank_gnt got=%b exp=010", gnt); end
      total++; if (rom_addr !== 11'h211) begin bad++; $display("FAIL prio_addr got=%h exp=211", rom_addr); end
      @(negedge clk); req = 3'b000; #1;
      total++; if (rvalid !== 3'b010) begin bad++; $display("FAIL prio_rvalid got=%b exp=010", rvalid); end
      total++; if (rdata !== 8'h49) begin bad++; $display("FAIL prio_rdata got=%h exp=49", rdata); end
      // Pointer is 2: requester 0 wins first while requester 1 waits.
      @(negedge clk); req = 3'b011; #1;
      total++; if (gnt !== 3'b001) begin bad++; $display("FAIL busy_gnt0 got=%b exp=001", gnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_wait got=%b exp=1", busy); end
      @(negedge clk); req = 3'b010; #1;
      total++; if (gnt !== 3'b010) begin bad++; $display("FAIL busy_gnt1 got=%b exp=010", gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b exp=0", busy); end
      total++; if (rdata !== 8'h5B) begin bad++; $display("FAIL busy_rdata got=%h exp=5b", rdata); end
      @(negedge clk); req = 3'b000;
   endtask

   task automatic test_reset_mid();
      @(negedge clk); req = 3'b010; #1;
      total++; if (gnt !== 3'b010) begin bad++; $display("FAIL rst_gnt got=%b exp=010", gnt); end
      @(negedge clk); req = 3'b000; #1;
      total++; if (rvalid !== 3'b010) begin bad++; $display("FAIL rst_pre_rvalid got=%b exp=010", rvalid); end
      reset = 1'b0; #1;
      total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL rst_rvalid got=%b exp=000", rvalid); end
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
      @(negedge clk); reset = 1'b1; req = 3'b111; #1;
      total++; if (gnt !== 3'b001) begin bad++; $display("FAIL rst_restart got=%b exp=001", gnt); end
      @(negedge clk); req = 3'b000;
   endtask

   initial begin
      test_reset();
      test_video();
      test_round_robin();
      test_wrap();
      test_last_blank();
      test_video_priority();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
